// File: rtl/spi_scan_master.sv
// SPI scan master: walks NCH channels of a pipelined ADC-style slave (SPI mode 3)
// and hands each returned conversion out on a valid/ready port tagged with its channel.
module spi_scan_master #(
    parameter int                 FRAME_W      = 16,
    parameter int                 NCH          = 4,
    parameter int                 ADDR_W       = 4,
    parameter int                 ADDR_LSB     = 7,
    parameter logic [FRAME_W-1:0] CMD_TEMPLATE = FRAME_W'(16'h1080),
    parameter int                 CLK_DIV      = 2
) (
    input  logic               CLK,
    input  logic               RSTbar,
    input  logic               START,
    input  logic               CONT,
    input  logic               MISO,
    output logic               SCK,
    output logic               MOSI,
    output logic               CSbar,
    output logic [FRAME_W-1:0] DATA,
    output logic [ADDR_W-1:0]  DCH,
    output logic               DVALID,
    input  logic               DREADY,
    output logic               BUSY,
    output logic               DONE
);

    localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int                 BIT_W    = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0]   DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [ADDR_W-1:0]  LAST_CH  = ADDR_W'(NCH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP,
        WAIT_OUT
    } state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_cnt, div_nx;
    logic [BIT_W-1:0]   bit_cnt, bit_nx;
    logic               ph, ph_nx;
    logic [ADDR_W-1:0]  addr, addr_nx;
    logic [ADDR_W-1:0]  tag;
    logic               first, first_nx;
    logic               last, last_nx;
    logic [FRAME_W-1:0] tx, tx_nx;
    logic [FRAME_W-1:0] rx, rx_nx;
    logic [FRAME_W-1:0] data_nx;
    logic [ADDR_W-1:0]  dch_nx;
    logic               dvalid_nx, sck_nx, mosi_nx, cs_nx, busy_nx, done_nx;
    logic               tick, adv;
    logic [FRAME_W-1:0] cmd;

    // The channel number is added into the template's address field (modulo the
    // field width), so a template whose field is zero gets the plain channel number.
    function automatic logic [FRAME_W-1:0] cmd_word(input logic [ADDR_W-1:0] a);
        logic [FRAME_W-1:0] w;
        logic [ADDR_W-1:0]  f;
        w = CMD_TEMPLATE;
        f = w[ADDR_LSB +: ADDR_W] + a;
        w[ADDR_LSB +: ADDR_W] = f;
        return w;
    endfunction

    assign tick = (div_cnt == DIV_MAX);
    assign cmd  = cmd_word(addr);
    // The slave answers one frame late, so the result belongs to the previous address.
    assign tag  = (addr == '0) ? LAST_CH : addr - 1'b1;

    always_comb begin
        state_nx  = state;
        div_nx    = tick ? '0 : div_cnt + 1'b1;
        bit_nx    = bit_cnt;
        ph_nx     = ph;
        addr_nx   = addr;
        first_nx  = first;
        last_nx   = last;
        tx_nx     = tx;
        rx_nx     = rx;
        data_nx   = DATA;
        dch_nx    = DCH;
        dvalid_nx = DVALID;
        sck_nx    = SCK;
        mosi_nx   = MOSI;
        cs_nx     = CSbar;
        busy_nx   = BUSY;
        done_nx   = 1'b0;
        adv       = 1'b0;

        if (DVALID && DREADY)
            dvalid_nx = 1'b0;

        case (state)
            IDLE: begin
                div_nx = '0;
                if (START) begin
                    state_nx = CS_SETUP;
                    busy_nx  = 1'b1;
                    cs_nx    = 1'b0;
                    addr_nx  = '0;
                    first_nx = 1'b1;
                    last_nx  = 1'b0;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    state_nx = SHIFT;
                    sck_nx   = 1'b0;
                    mosi_nx  = cmd[FRAME_W-1];
                    tx_nx    = {cmd[FRAME_W-2:0], 1'b0};
                    ph_nx    = 1'b0;
                    bit_nx   = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!ph) begin
                        sck_nx = 1'b1;
                        rx_nx  = {rx[FRAME_W-2:0], MISO};
                        ph_nx  = 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        state_nx = CS_HOLD;
                    end else begin
                        bit_nx  = bit_cnt + 1'b1;
                        ph_nx   = 1'b0;
                        sck_nx  = 1'b0;
                        mosi_nx = tx[FRAME_W-1];
                        tx_nx   = {tx[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_nx = CS_GAP;
                    cs_nx    = 1'b1;
                    mosi_nx  = 1'b0;
                    first_nx = 1'b0;
                    if (!first) begin
                        data_nx   = rx;
                        dch_nx    = tag;
                        dvalid_nx = 1'b1;
                        last_nx   = (tag == LAST_CH) && !CONT;
                    end
                end
            end
            CS_GAP: begin
                if (tick) begin
                    if (DVALID && !DREADY)
                        state_nx = WAIT_OUT;
                    else
                        adv = 1'b1;
                end
            end
            WAIT_OUT: begin
                div_nx = '0;
                if (!DVALID || DREADY)
                    adv = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Next frame only starts once the output slot is free, so nothing is overwritten.
        if (adv) begin
            if (last) begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                last_nx  = 1'b0;
            end else begin
                state_nx = CS_SETUP;
                cs_nx    = 1'b0;
                addr_nx  = (addr == LAST_CH) ? '0 : addr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            ph      <= 1'b0;
            addr    <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
            tx      <= '0;
            rx      <= '0;
            DATA    <= '0;
            DCH     <= '0;
            DVALID  <= 1'b0;
            SCK     <= 1'b1;
            MOSI    <= 1'b0;
            CSbar   <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            ph      <= ph_nx;
            addr    <= addr_nx;
            first   <= first_nx;
            last    <= last_nx;
            tx      <= tx_nx;
            rx      <= rx_nx;
            DATA    <= data_nx;
            DCH     <= dch_nx;
            DVALID  <= dvalid_nx;
            SCK     <= sck_nx;
            MOSI    <= mosi_nx;
            CSbar   <= cs_nx;
            BUSY    <= busy_nx;
            DONE    <= done_nx;
        end
    end

endmodule
